// File: rtl/fpu_sp.sv
// rtl/fpu_sp.sv - single-precision IEEE-754 add/sub/mul/div unit with launch/complete handshake
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  asynchronous active-high reset
//   cmd    in   4  1=ADD 2=SUB 3=MUL 4=DIV, others return NaN
//   din1   in  32  operand A
//   din2   in  32  operand B
//   dval   in   1  launch strobe, accepted only when idle
//   result out 32  registered result, held until the next completion
//   rdy    out  1  one-cycle completion pulse
//
// Build option: FPU_SP_DIV_EN builds the 26-step restoring divider (DIV latency 28);
// without it DIV completes in 3 cycles with the canonical NaN.

module fpu_sp (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cmd,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    input  logic        dval,
    output logic [31:0] result,
    output logic        rdy
);

    localparam logic [3:0]  OP_ADD = 4'd1;
    localparam logic [3:0]  OP_SUB = 4'd2;
    localparam logic [3:0]  OP_MUL = 4'd3;
    localparam logic [3:0]  OP_DIV = 4'd4;
    localparam logic [31:0] QNAN   = 32'h7FC00000;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [4:0]  cnt_q;
    logic [31:0] result_q;
    logic        calc_done;
    logic [31:0] calc_res;

    // Index-of-first-one from the top; 32 when x is zero.
    function automatic logic [5:0] clz32(input logic [31:0] x);
        clz32 = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) clz32 = 6'(31 - i);
        end
    endfunction

    // Right shifts that fold every shifted-out bit into bit 0 (sticky).
    function automatic logic [26:0] shr27(input logic [26:0] x, input logic [9:0] sh);
        logic [26:0] r;
        logic [26:0] lost;
        if (sh >= 10'd27) return {26'b0, |x};
        r    = x >> sh;
        lost = x & ~(27'h7FFFFFF << sh);
        return {r[26:1], r[0] | (|lost)};
    endfunction

    function automatic logic [25:0] shr26(input logic [25:0] x, input logic [9:0] sh);
        logic [25:0] r;
        logic [25:0] lost;
        if (sh >= 10'd26) return {25'b0, |x};
        r    = x >> sh;
        lost = x & ~(26'h3FFFFFF << sh);
        return {r[25:1], r[0] | (|lost)};
    endfunction

    // Operand -> {signed biased exponent, 24-bit mantissa with the leading one at bit 23}.
    // Denormals are normalised here, so their exponent may drop below 1.
    function automatic logic [33:0] unpack(input logic [31:0] x);
        logic [23:0]       m0;
        logic [5:0]        lz;
        logic signed [9:0] e;
        m0 = {|x[30:23], x[22:0]};
        lz = clz32({8'b0, m0}) - 6'd8;
        e  = (x[30:23] == 8'd0) ? 10'sd1 : $signed({2'b0, x[30:23]});
        e  = e - $signed({4'b0, lz});
        return {e, m0 << lz};
    endfunction

    // m: [25] leading one, [24:2] fraction, [1] guard, [0] sticky; e: biased exponent of m[25].
    // Exponents below 1 are denormalised first. The leading bit is added into the exponent
    // field, so a rounding carry rolls naturally into the next binade or into Inf.
    function automatic logic [31:0] round_pack(input logic sign, input logic signed [9:0] e,
                                               input logic [25:0] m);
        logic [25:0] mm;
        logic [7:0]  ef;
        logic        inc;
        logic [30:0] body;
        if (e >= 10'sd255) return {sign, 8'hFF, 23'h0};
        if (e < 10'sd1) begin
            mm = shr26(m, $unsigned(10'sd1 - e));
            ef = 8'd0;
        end else begin
            mm = m;
            ef = 8'(e - 10'sd1);
        end
        inc  = mm[1] & (mm[0] | mm[2]);
        body = {ef, 23'b0} + {7'b0, mm[25:2]} + {30'b0, inc};
        return {sign, body};
    endfunction

    // Operand decode
    logic              sa, sb;
    logic signed [9:0] ea, eb;
    logic [23:0]       ma, mb;
    logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    always_comb begin
        sa     = a_q[31];
        sb     = b_q[31];
        {ea, ma} = unpack(a_q);
        {eb, mb} = unpack(b_q);
        a_nan  = (&a_q[30:23]) & (|a_q[22:0]);
        a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
        a_zero = ~(|a_q[30:0]);
        b_nan  = (&b_q[30:23]) & (|b_q[22:0]);
        b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
        b_zero = ~(|b_q[30:0]);
    end

    // ADD / SUB
    logic              sb_eff, sx, sy;
    logic signed [9:0] ex, ey, add_e;
    logic [23:0]       mx_m, my_m;
    logic [26:0]       my, n;
    logic [27:0]       s;
    logic [5:0]        z;
    logic [31:0]       add_res;

    always_comb begin
        sb_eff = sb ^ (op_q == OP_SUB);
        // Larger magnitude goes to x so the aligned difference is never negative.
        if ((ea > eb) || ((ea == eb) && (ma >= mb))) begin
            {sx, ex, mx_m} = {sa, ea, ma};
            {sy, ey, my_m} = {sb_eff, eb, mb};
        end else begin
            {sx, ex, mx_m} = {sb_eff, eb, mb};
            {sy, ey, my_m} = {sa, ea, ma};
        end
        my = shr27({my_m, 3'b0}, $unsigned(ex - ey));
        s  = (sx == sy) ? {1'b0, mx_m, 3'b0} + {1'b0, my}
                        : {1'b0, mx_m, 3'b0} - {1'b0, my};
        z  = clz32({4'b0, s}) - 6'd4;
        if (z == 6'd0) begin
            n     = {s[27:2], s[1] | s[0]};
            add_e = ex + 10'sd1;
        end else begin
            n     = s[26:0] << (z - 6'd1);
            add_e = ex - $signed({4'b0, z}) + 10'sd1;
        end

        if (a_nan || b_nan)
            add_res = QNAN;
        else if (a_inf && b_inf && (sa != sb_eff))
            add_res = QNAN;
        else if (a_inf)
            add_res = {sa, 8'hFF, 23'h0};
        else if (b_inf)
            add_res = {sb_eff, 8'hFF, 23'h0};
        else if (a_zero && b_zero)
            add_res = {sa & sb_eff, 31'h0};
        else if (s == 28'd0)
            add_res = 32'h0;          // exact cancellation is +0
        else
            add_res = round_pack(sx, add_e, {n[26:2], |n[1:0]});
    end

    // MUL
    logic [47:0]       p;
    logic signed [9:0] mul_e;
    logic [25:0]       mul_m;
    logic              sxor;
    logic [31:0]       mul_res;

    always_comb begin
        sxor  = sa ^ sb;
        p     = {24'b0, ma} * {24'b0, mb};
        mul_e = ea + eb - 10'sd127 + (p[47] ? 10'sd1 : 10'sd0);
        mul_m = p[47] ? {p[47:23], |p[22:0]} : {p[46:22], |p[21:0]};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            mul_res = QNAN;
        else if (a_inf || b_inf)
            mul_res = {sxor, 8'hFF, 23'h0};
        else if (a_zero || b_zero)
            mul_res = {sxor, 31'h0};
        else
            mul_res = round_pack(sxor, mul_e, mul_m);
    end

    // DIV
    logic [31:0] div_res;
    logic        is_div;

`ifdef FPU_SP_DIV_EN
    logic [25:0]       rem_q, q_q;
    logic signed [9:0] div_e;
    logic [25:0]       div_m;
    logic              rem_nz;

    always_comb begin
        is_div = (op_q == OP_DIV);
        rem_nz = |rem_q;
        // Quotient lies in (0.5, 2): q_q[25] set means the integer bit is one.
        div_m  = q_q[25] ? {q_q[25:1], q_q[0] | rem_nz} : {q_q[24:0], rem_nz};
        div_e  = ea - eb + (q_q[25] ? 10'sd127 : 10'sd126);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            div_res = QNAN;
        else if (b_zero || a_inf)
            div_res = {sxor, 8'hFF, 23'h0};
        else if (a_zero || b_inf)
            div_res = {sxor, 31'h0};
        else
            div_res = round_pack(sxor, div_e, div_m);
    end

    // Step 0 loads the dividend, steps 1..26 each produce one quotient bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= 26'd0;
            q_q   <= 26'd0;
        end else if (state_q == CALC) begin
            if (cnt_q == 5'd0) begin
                rem_q <= {2'b0, ma};
                q_q   <= 26'd0;
            end else if (cnt_q <= 5'd26) begin
                if (rem_q >= {2'b0, mb}) begin
                    rem_q <= (rem_q - {2'b0, mb}) << 1;
                    q_q   <= {q_q[24:0], 1'b1};
                end else begin
                    rem_q <= rem_q << 1;
                    q_q   <= {q_q[24:0], 1'b0};
                end
            end
        end
    end
`else
    always_comb begin
        is_div  = 1'b0;
        div_res = QNAN;
    end
`endif

    always_comb begin
        case (op_q)
            OP_ADD, OP_SUB: calc_res = add_res;
            OP_MUL:         calc_res = mul_res;
            OP_DIV:         calc_res = div_res;
            default:        calc_res = QNAN;
        endcase
    end

    // cnt_q counts CALC cycles; completion edge gives 3 or 28 cycles from launch.
    assign calc_done = is_div ? (cnt_q == 5'd27) : (cnt_q == 5'd2);

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dval) state_d = CALC;
            CALC:    if (calc_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        rdy    = (state_q == DONE);
        result = result_q;
    end

    // Operand capture, cycle counter and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dval) begin
                        op_q  <= cmd;
                        a_q   <= din1;
                        b_q   <= din2;
                        cnt_q <= 5'd0;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (calc_done) result_q <= calc_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_sp.sv
// tb/tb_fpu_sp.sv - directed-vector self-checking bench for fpu_sp

module tb_fpu_sp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cmd = 4'd0;
    logic [31:0] din1 = 32'd0;
    logic [31:0] din2 = 32'd0;
    logic        dval = 1'b0;
    logic [31:0] result;
    logic        rdy;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] ADD = 4'd1;
    localparam logic [3:0] SUB = 4'd2;
    localparam logic [3:0] MUL = 4'd3;
    localparam logic [3:0] DIV = 4'd4;

`ifdef FPU_SP_DIV_EN
    localparam int          DIV_LAT = 28;
    localparam logic [31:0] DIV_33  = 32'h3F800000;
`else
    localparam int          DIV_LAT = 3;
    localparam logic [31:0] DIV_33  = 32'h7FC00000;
`endif

    always #5 clk = ~clk;

    fpu_sp dut (
        .clk    (clk),
        .rst    (rst),
        .cmd    (cmd),
        .din1   (din1),
        .din2   (din2),
        .dval   (dval),
        .result (result),
        .rdy    (rdy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one op, count edges to rdy, check result, latency and single-cycle pulse.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        @(negedge clk);
        cmd = c; din1 = a; din2 = b; dval = 1'b1;
        @(posedge clk); #1;
        dval = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rdy && lat < 40);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_lat"}, lat, exp_lat);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'b0, rdy}, 32'd0);
    endtask

    initial begin
        int lat;
        int extra;

        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 32'h0);
        check("reset_rdy", {31'b0, rdy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_1p2",   ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 3);
        run_op("add_cancel",ADD, 32'hC0400000, 32'h40400000, 32'h00000000, 3);
        run_op("add_infinf",ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 3);
        run_op("add_den1",  ADD, 32'h00000001, 32'h3F800000, 32'h3F800000, 3);
        run_op("add_dd",    ADD, 32'h00000001, 32'h00000001, 32'h00000002, 3);
        run_op("add_ovf",   ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3);
        run_op("add_nanpl", ADD, 32'h7F812345, 32'h3F800000, 32'h7FC00000, 3);
        run_op("add_negz",  ADD, 32'h80000000, 32'h80000000, 32'h80000000, 3);
        run_op("sub_2m1",   SUB, 32'h40000000, 32'h3F800000, 32'h3F800000, 3);
        run_op("sub_m3m3",  SUB, 32'hC0400000, 32'h40400000, 32'hC0C00000, 3);
        run_op("sub_inf",   SUB, 32'h7F800000, 32'hFF800000, 32'h7F800000, 3);
        run_op("sub_den",   SUB, 32'h00000001, 32'h3F800000, 32'hBF800000, 3);
        run_op("mul_m9",    MUL, 32'hC0400000, 32'h40400000, 32'hC1100000, 3);
        run_op("mul_inf0",  MUL, 32'h7F800000, 32'h00000000, 32'h7FC00000, 3);
        run_op("mul_den",   MUL, 32'h00000001, 32'h3F800000, 32'h00000001, 3);
        run_op("mul_nan",   MUL, 32'h7FC00000, 32'h40400000, 32'h7FC00000, 3);
        run_op("bad_cmd",   4'd0, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 3);
`ifdef FPU_SP_DIV_EN
        run_op("div_33",    DIV, 32'h40400000, 32'h40400000, 32'h3F800000, 28);
        run_op("div_m33",   DIV, 32'hC0400000, 32'h40400000, 32'hBF800000, 28);
        run_op("div_x0",    DIV, 32'h40400000, 32'h00000000, 32'h7F800000, 28);
        run_op("div_infinf",DIV, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 28);
        run_op("div_ovf",   DIV, 32'h3F800000, 32'h00000001, 32'h7F800000, 28);
        run_op("div_1by3",  DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28);
`else
        run_op("div_off",   DIV, 32'h40400000, 32'h40400000, 32'h7FC00000, 3);
`endif

        // A second dval while busy must be dropped.
        @(negedge clk);
        cmd = DIV; din1 = 32'h40400000; din2 = 32'h40400000; dval = 1'b1;
        @(posedge clk); #1;
        dval = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                cmd = ADD; din1 = 32'h3F800000; din2 = 32'h40000000; dval = 1'b1;
            end else begin
                dval = 1'b0;
            end
        end while (!rdy && lat < 40);
        dval = 1'b0;
        check("busy_res", result, DIV_33);
        check("busy_lat", lat, DIV_LAT);
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rdy) extra++;
        end
        check("busy_norerun", extra, 0);

        // Reset in the middle of an operation aborts it.
        @(negedge clk);
        cmd = DIV; din1 = 32'hC0400000; din2 = 32'h40400000; dval = 1'b1;
        @(posedge clk); #1;
        dval = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_rdy", {31'b0, rdy}, 32'd0);
        check("rst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (rdy) extra++;
        end
        check("rst_no_rdy", extra, 0);
        run_op("add_after_rst", ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
